// File: rtl/range_match_pkg.sv
// Shared types for the range match sequencer: FSM state, table entry layout and
// entry kind codes. The wildcard entry kind is only honoured when the design is
// built with RANGE_MATCH_WILDCARD_EN defined.
package range_match_pkg;

    // Bound/pattern width held in each table entry; the top's DATA_W must equal this.
    localparam int ENTRY_DATA_W = 32;

    localparam logic KIND_RANGE = 1'b0;
    localparam logic KIND_WILD  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        RESP
    } state_t;

    typedef struct packed {
        logic                    en;
        logic                    kind;
        logic [ENTRY_DATA_W-1:0] lo;
        logic [ENTRY_DATA_W-1:0] hi;
        logic [ENTRY_DATA_W-1:0] mask;
    } entry_t;

endpackage

// File: rtl/range_match_cmp.sv
// Single-entry comparator: decides whether one table entry contains a value.
// This is the one comparator the sequencer time-shares across all entries.
// With RANGE_MATCH_WILDCARD_EN defined, kind=1 entries match on masked equality;
// otherwise every entry is an inclusive unsigned range.
module range_match_cmp
    import range_match_pkg::*;
#(
    parameter int DATA_W = ENTRY_DATA_W
) (
    input  entry_t             entry,
    input  logic [DATA_W-1:0]  value,
    output logic               match
);

`ifndef RANGE_MATCH_WILDCARD_EN
    // Kind and mask carry no meaning in a range-only build.
    logic unused_fields;
    assign unused_fields = ^{entry.kind, entry.mask};
`endif

    // Match decision for the entry currently presented by the sequencer.
    always_comb begin
        match = 1'b0;
        if (entry.en) begin
`ifdef RANGE_MATCH_WILDCARD_EN
            if (entry.kind == KIND_WILD) begin
                match = ((value ^ entry.lo) & ~entry.mask) == '0;
            end else begin
                match = (value >= entry.lo) && (value <= entry.hi);
            end
`else
            // lo > hi can never satisfy both bounds, so it never matches.
            match = (value >= entry.lo) && (value <= entry.hi);
`endif
        end
    end

endmodule

// File: rtl/range_match_sequencer.sv
// Priority set-membership classifier. A query is latched, then the table is
// scanned one entry per cycle through a single comparator; the first (lowest
// index) enabled entry containing the value is reported, or a miss after the
// last entry. Table writes are accepted in any state.
// Optional feature: define RANGE_MATCH_WILDCARD_EN to enable wildcard entries.
module range_match_sequencer
    import range_match_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int ENTRIES = 8,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic              cfg_en,
    input  logic              cfg_kind,
    input  logic [DATA_W-1:0] cfg_lo,
    input  logic [DATA_W-1:0] cfg_hi,
    input  logic [DATA_W-1:0] cfg_mask,
    input  logic              q_valid,
    output logic              q_ready,
    input  logic [DATA_W-1:0] q_data,
    output logic              r_valid,
    input  logic              r_ready,
    output logic              r_hit,
    output logic [IDX_W-1:0]  r_idx,
    output logic              busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    entry_t            table_q [ENTRIES];
    state_t            state_q;
    state_t            state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] value_q;
    logic              hit_q;
    logic [IDX_W-1:0]  hit_idx_q;
    logic              match;
    logic              accept;
    logic              scan_end;
    logic              last_entry;

`ifndef RANGE_MATCH_WILDCARD_EN
    // Wildcard configuration is not stored in a range-only build.
    logic unused_cfg;
    assign unused_cfg = ^{cfg_kind, cfg_mask};
`endif

    // Table storage: cleared on reset, one entry written per cfg_we cycle.
    // NOTE: this table is reset explicitly because reset must disable every
    // entry; storage without such a requirement is better left unreset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and the scan compares the old entry contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '0;
            end
        end else if (cfg_we && (int'(cfg_idx) < ENTRIES)) begin
            table_q[cfg_idx].en <= cfg_en;
            table_q[cfg_idx].lo <= cfg_lo;
            table_q[cfg_idx].hi <= cfg_hi;
`ifdef RANGE_MATCH_WILDCARD_EN
            table_q[cfg_idx].kind <= cfg_kind;
            table_q[cfg_idx].mask <= cfg_mask;
`endif
        end
    end

    range_match_cmp #(
        .DATA_W (DATA_W)
    ) u_cmp (
        .entry (table_q[idx_q]),
        .value (value_q),
        .match (match)
    );

    // Next-state and handshake decode for the IDLE/SCAN/RESP sequence.
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        q_ready    = 1'b0;
        r_valid    = 1'b0;
        busy       = 1'b1;
        last_entry = (idx_q == LAST_IDX);
        accept     = 1'b0;
        scan_end   = 1'b0;
        unique case (state_q)
            IDLE: begin
                q_ready = 1'b1;
                busy    = 1'b0;
                accept  = q_valid;
                if (q_valid) state_d = SCAN;
            end
            SCAN: begin
                scan_end = match || last_entry;
                if (scan_end) state_d = RESP;
            end
            RESP: begin
                r_valid = 1'b1;
                if (r_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register plus latched query, scan pointer and held response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            value_q   <= '0;
            hit_q     <= 1'b0;
            hit_idx_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                value_q <= q_data;
                idx_q   <= '0;
            end else if (state_q == SCAN && !scan_end) begin
                idx_q <= idx_q + 1'b1;
            end
            if (scan_end) begin
                hit_q     <= match;
                hit_idx_q <= match ? idx_q : '0;
            end
        end
    end

    assign r_hit = hit_q;
    assign r_idx = hit_idx_q;

endmodule

// File: tb/tb_range_match_sequencer.sv
// Randomised plus directed bench for range_match_sequencer. A behavioural table
// model predicts each response (first matching entry, latency from its index),
// which a monitor compares when the DUT presents it.
module tb_range_match_sequencer;

    localparam int DATA_W  = 32;
    localparam int ENTRIES = 8;
    localparam int IDX_W   = $clog2(ENTRIES);

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_idx;
    logic              cfg_en;
    logic              cfg_kind;
    logic [DATA_W-1:0] cfg_lo;
    logic [DATA_W-1:0] cfg_hi;
    logic [DATA_W-1:0] cfg_mask;
    logic              q_valid;
    logic              q_ready;
    logic [DATA_W-1:0] q_data;
    logic              r_valid;
    logic              r_ready = 1'b1;
    logic              r_hit;
    logic [IDX_W-1:0]  r_idx;
    logic              busy;

    range_match_sequencer #(
        .DATA_W  (DATA_W),
        .ENTRIES (ENTRIES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_idx  (cfg_idx),
        .cfg_en   (cfg_en),
        .cfg_kind (cfg_kind),
        .cfg_lo   (cfg_lo),
        .cfg_hi   (cfg_hi),
        .cfg_mask (cfg_mask),
        .q_valid  (q_valid),
        .q_ready  (q_ready),
        .q_data   (q_data),
        .r_valid  (r_valid),
        .r_ready  (r_ready),
        .r_hit    (r_hit),
        .r_idx    (r_idx),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit          en;
        bit          kind;
        int unsigned lo;
        int unsigned hi;
        int unsigned mask;
    } ment_t;

    typedef struct packed {
        bit hit;
        int idx;
        int exp_c;
    } exp_t;

    ment_t model [ENTRIES];
    exp_t  sb [$];
    exp_t  cur;
    int    vectors     = 0;
    int    miscompares = 0;
    int    cyc         = 0;
    bit    in_resp     = 0;
    bit    rdy_rand    = 0;
    bit    rdy_hold0   = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit entry_hit(input ment_t e, input int unsigned v);
        if (!e.en) return 1'b0;
`ifdef RANGE_MATCH_WILDCARD_EN
        if (e.kind) return (v & ~e.mask) == (e.lo & ~e.mask);
`endif
        return (v >= e.lo) && (v <= e.hi);
    endfunction

    // Reference: lowest enabled containing entry wins; latency k+2 on hit, ENTRIES+1 on miss.
    function automatic exp_t predict(input int unsigned v);
        exp_t e;
        e.hit   = 1'b0;
        e.idx   = 0;
        e.exp_c = ENTRIES + 1;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!e.hit && entry_hit(model[i], v)) begin
                e.hit   = 1'b1;
                e.idx   = i;
                e.exp_c = i + 2;
            end
        end
        return e;
    endfunction

    // Response ready: held low on request, random in the random phase, else high.
    always @(posedge clk) begin
        #1;
        r_ready = rdy_hold0 ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    end

    // Monitor: pop the prediction when a response first appears, then check it stays put.
    always @(negedge clk) begin
        if (rst) begin
            in_resp = 0;
        end else if (r_valid) begin
            if (!in_resp) begin
                if (sb.size() == 0) begin
                    check("unexpected_response", 1, 0);
                end else begin
                    cur = sb.pop_front();
                    check("r_hit", r_hit, cur.hit);
                    check("r_idx", r_idx, cur.idx);
                    check("latency", cyc, cur.exp_c);
                end
                in_resp = 1;
            end else begin
                check("r_hit_stable", r_hit, cur.hit);
                check("r_idx_stable", r_idx, cur.idx);
            end
            check("q_ready_in_resp", q_ready, 0);
            if (r_ready) in_resp = 0;
        end
    end

    task automatic set_cfg(input int idx, input bit en, input bit kind,
                           input int unsigned lo, input int unsigned hi, input int unsigned mask);
        cfg_we   = 1'b1;
        cfg_idx  = IDX_W'(idx);
        cfg_en   = en;
        cfg_kind = kind;
        cfg_lo   = lo;
        cfg_hi   = hi;
        cfg_mask = mask;
        model[idx] = '{en: en, kind: kind, lo: lo, hi: hi, mask: mask};
    endtask

    task automatic cfg_write(input int idx, input bit en, input bit kind,
                             input int unsigned lo, input int unsigned hi, input int unsigned mask);
        set_cfg(idx, en, kind, lo, hi, mask);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(q_ready && sb.size() == 0 && !in_resp)) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                check("idle_timeout", 0, 1);
                sb.delete();
                return;
            end
        end
    endtask

    // Presents one query at a negedge while idle; the accept edge is the next posedge.
    task automatic issue_query(input int unsigned v);
        exp_t e;
        e = predict(v);
        e.exp_c = e.exp_c + cyc;
        sb.push_back(e);
        q_valid = 1'b1;
        q_data  = v;
        @(negedge clk);
        q_valid = 1'b0;
    endtask

    task automatic query(input int unsigned v);
        wait_idle();
        issue_query(v);
        wait_idle();
    endtask

    task automatic clear_table();
        for (int i = 0; i < ENTRIES; i++) cfg_write(i, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_kind = 1'b0;
        cfg_lo = '0; cfg_hi = '0; cfg_mask = '0; q_valid = 1'b0; q_data = '0;
        for (int i = 0; i < ENTRIES; i++) model[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_r_valid", r_valid, 0);
        check("reset_r_hit", r_hit, 0);
        check("reset_r_idx", r_idx, 0);
        check("reset_busy", busy, 0);
        check("reset_q_ready", q_ready, 1);
        query(16);

        // Table sweep
        cfg_write(0, 1, 0, 16, 23, 0);
        cfg_write(1, 1, 0, 32, 47, 0);
        cfg_write(2, 1, 0, 60, 61, 0);
        cfg_write(3, 1, 0, 0, 0, 0);
        cfg_write(4, 1, 0, 4, 4, 0);
        for (int v = 0; v < 64; v++) query(v);

        // Priority and latency
        clear_table();
        cfg_write(0, 1, 0, 10, 20, 0);
        cfg_write(1, 1, 0, 15, 15, 0);
        query(15);
        cfg_write(0, 0, 0, 10, 20, 0);
        query(15);

        // Miss latency with response backpressure
        clear_table();
        rdy_hold0 = 1;
        wait_idle();
        issue_query(5);
        for (int n = 0; n < 50 && !in_resp; n++) @(negedge clk);
        check("resp_seen", in_resp, 1);
        repeat (4) @(negedge clk);
        rdy_hold0 = 0;
        wait_idle();

        // Writes during the scan
        cfg_write(0, 1, 0, 0, 1, 0);
        cfg_write(1, 1, 0, 2, 3, 0);
        model[3] = '{en: 1, kind: 0, lo: 50, hi: 50, mask: 0};
        wait_idle();
        issue_query(50);
        @(negedge clk);
        cfg_write(3, 1, 0, 50, 50, 0);
        wait_idle();
        issue_query(50);
        @(negedge clk);
        cfg_write(1, 1, 0, 50, 50, 0);
        wait_idle();

        // Reset during a scan
        cfg_write(0, 1, 0, 16, 23, 0);
        wait_idle();
        issue_query(63);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < ENTRIES; i++) model[i] = '0;
        check("rst_r_valid", r_valid, 0);
        check("rst_q_ready", q_ready, 1);
        check("rst_busy", busy, 0);
        query(16);

        // Wildcard entry (range [3,0] when the feature is absent)
        clear_table();
        cfg_write(0, 1, 1, 3, 0, 4);
        query(3);
        query(7);
        query(1);

        // Random table and queries with random backpressure and concurrent writes
        rdy_rand = 1;
        for (int t = 0; t < 60; t++) begin
            int unsigned lo;
            wait_idle();
            if ($urandom_range(0, 2) == 0) begin
                lo = $urandom_range(0, 63);
                cfg_write($urandom_range(0, ENTRIES - 1), 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)), lo,
                          ($urandom_range(0, 5) == 0) ? lo - 1 : lo + $urandom_range(0, 8),
                          $urandom_range(0, 63));
            end
            if ($urandom_range(0, 3) == 0) begin
                lo = $urandom_range(0, 63);
                set_cfg($urandom_range(0, ENTRIES - 1), 1, 0, lo, lo + $urandom_range(0, 4), 0);
                issue_query($urandom_range(0, 63));
                cfg_we = 1'b0;
            end else begin
                issue_query($urandom_range(0, 63));
            end
        end
        wait_idle();
        rdy_rand = 0;
        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
